// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM state and requester IDs for the memory arbiter.
package mem_arbiter_pkg;
  localparam int ARCH_BITS = 32;
  localparam int MEMORY_LINE_BITS = 128;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} stateT;
  typedef enum logic [1:0] {SRC_D = 2'd0, SRC_I = 2'd1, SRC_W = 2'd2} srcT;
  function automatic srcT nextSrc(srcT s);
    return s == SRC_D ? SRC_I : s == SRC_I ? SRC_W : SRC_D;
  endfunction
endpackage

// File: rtl/mem_arbiter_select.sv
// arb_select: combinational winner pick among d/i/w requests.
// MEM_ARBITER_RR_EN selects round-robin from ptr; otherwise fixed d>i>w with starvation escape.
module arb_select
  import mem_arbiter_pkg::*;
(
  input  logic [2:0] reqs,
  input  logic       starveHit,
  input  srcT        ptr,
  output srcT        src
);
`ifdef MEM_ARBITER_RR_EN
  srcT p1, p2;
  logic unusedStarve;
  assign p1 = nextSrc(ptr);
  assign p2 = nextSrc(p1);
  assign src = reqs[ptr] ? ptr : reqs[p1] ? p1 : p2;
  assign unusedStarve = starveHit;
`else
  logic [1:0] unusedPtr;
  assign unusedPtr = ptr;
  assign src = starveHit ? SRC_W : reqs[SRC_D] ? SRC_D : reqs[SRC_I] ? SRC_I : SRC_W;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serves i-cache reads, d-cache reads and store-buffer writes on one fixed-latency memory port.
// Build with MEM_ARBITER_RR_EN for round-robin selection instead of fixed priority.
module mem_arbiter #(
  parameter int ARCH_BITS    = mem_arbiter_pkg::ARCH_BITS,
  parameter int LINE_BITS    = mem_arbiter_pkg::MEMORY_LINE_BITS,
  parameter int OFFSET_BITS  = 4,
  parameter int MEM_LATENCY  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iReq,
  input  logic [ARCH_BITS-1:0] iAddr,
  output logic [LINE_BITS-1:0] iLine,
  output logic                 iValid,
  input  logic                 dReq,
  input  logic [ARCH_BITS-1:0] dAddr,
  output logic [LINE_BITS-1:0] dLine,
  output logic                 dValid,
  input  logic                 wReq,
  input  logic [ARCH_BITS-1:0] wAddr,
  input  logic [LINE_BITS-1:0] wLine,
  output logic                 wAck,
  output logic [ARCH_BITS-1:0] memAddr,
  output logic                 memRE,
  output logic                 memWE,
  output logic [LINE_BITS-1:0] memWData,
  input  logic [LINE_BITS-1:0] memRData
);
  import mem_arbiter_pkg::*;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  stateT state;
  srcT src, ptr, pick, respSrc;
  logic [3:0] cnt;
  logic [SW-1:0] starve;
  logic [2:0] reqs;
  logic anyReq, starveHit, goResp;
  logic [ARCH_BITS-1:0] addr;
  assign reqs = {wReq, iReq, dReq};
  assign anyReq = |reqs;
  assign starveHit = wReq && starve == SW'(STARVE_LIMIT);
  assign addr = pick == SRC_D ? dAddr : pick == SRC_I ? iAddr : wAddr;
  // goResp marks the edge that enters RESP; pulses are registered on that edge
  assign goResp = state == IDLE ? anyReq && MEM_LATENCY == 1 : state == BUSY && cnt == 4'd1;
  assign respSrc = state == IDLE ? pick : src;
  assign iLine = iValid ? memRData : '0;
  assign dLine = dValid ? memRData : '0;
  arb_select uSel (.reqs(reqs), .starveHit(starveHit), .ptr(ptr), .src(pick));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      starve   <= '0;
      src      <= SRC_D;
      ptr      <= SRC_D;
      memAddr  <= '0;
      memWData <= '0;
      iValid   <= 1'b0;
      dValid   <= 1'b0;
      wAck     <= 1'b0;
      memRE    <= 1'b0;
      memWE    <= 1'b0;
    end else begin
      iValid <= goResp && respSrc == SRC_I;
      dValid <= goResp && respSrc == SRC_D;
      wAck   <= goResp && respSrc == SRC_W;
      memRE  <= goResp && respSrc != SRC_W;
      memWE  <= goResp && respSrc == SRC_W;
      case (state)
        IDLE: begin
          starve <= (!wReq || pick == SRC_W) ? '0 : starve == SW'(STARVE_LIMIT) ? starve : starve + SW'(1);
          if (anyReq) begin
            state   <= goResp ? RESP : BUSY;
            cnt     <= 4'(MEM_LATENCY - 1);
            src     <= pick;
            ptr     <= nextSrc(pick);
            memAddr <= {addr[ARCH_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            if (pick == SRC_W) memWData <= wLine;
          end
        end
        BUSY: begin
          if (cnt == 4'd1) state <= RESP;
          cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int L = 4;
  localparam int SL = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [2:0] rq = '0, hold = '0, owed = '0, dropped = '0;
  logic [31:0] ad [3];
  logic [127:0] wData = '0, pattern = '0;
  logic mixAddr = 1'b0;
  logic [127:0] iLine, dLine, memWData, memRData, iLine1, dLine1, memWData1, memRData1;
  logic [31:0] memAddr, memAddr1;
  logic iValid, dValid, wAck, memRE, memWE, iValid1, dValid1, wAck1, memRE1, memWE1;
  assign memRData = pattern ^ (mixAddr ? {4{memAddr}} : 128'd0);
  assign memRData1 = pattern;

  mem_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .iReq(rq[1]), .iAddr(ad[1]), .iLine(iLine), .iValid(iValid),
    .dReq(rq[0]), .dAddr(ad[0]), .dLine(dLine), .dValid(dValid),
    .wReq(rq[2]), .wAddr(ad[2]), .wLine(wData), .wAck(wAck),
    .memAddr(memAddr), .memRE(memRE), .memWE(memWE), .memWData(memWData), .memRData(memRData));
  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(SL)) dut1 (
    .clk(clk), .rst(rst), .iReq(rq[1]), .iAddr(ad[1]), .iLine(iLine1), .iValid(iValid1),
    .dReq(rq[0]), .dAddr(ad[0]), .dLine(dLine1), .dValid(dValid1),
    .wReq(rq[2]), .wAddr(ad[2]), .wLine(wData), .wAck(wAck1),
    .memAddr(memAddr1), .memRE(memRE1), .memWE(memWE1), .memWData(memWData1), .memRData(memRData1));

  int tests = 0, fails = 0;
  int cyc = 0, freeCyc = 0, respCyc = -1, respSrc = -1, starve = 0, lastWin = 2, dropSrc = -1;
  logic [31:0] respAddr;
  logic [127:0] respData;
  int dutLog[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int pickModel();
`ifdef MEM_ARBITER_RR_EN
    for (int k = 0; k < 3; k++) if (rq[(lastWin + 1 + k) % 3]) return (lastWin + 1 + k) % 3;
`else
    if (rq[2] && starve >= SL) return 2;
    for (int k = 0; k < 3; k++) if (rq[k]) return k;
`endif
    return -1;
  endfunction

  task automatic step();
    logic [4:0] e;
    @(posedge clk);
    #1;
    cyc++;
    e = '0;
    if (respSrc >= 0 && respCyc == cyc) e = respSrc == 0 ? 5'b10010 : respSrc == 1 ? 5'b01010 : 5'b00101;
    chk("pulses", {dValid, iValid, wAck, memRE, memWE}, e);
    if (e != 0) begin
      chk("memAddr", memAddr, respAddr);
      if (respSrc == 0) chk("dLine", dLine, respData);
      else if (respSrc == 1) chk("iLine", iLine, respData);
      else chk("memWData", memWData, respData);
    end
    if (dValid) dutLog.push_back(0);
    if (iValid) dutLog.push_back(1);
    if (wAck) dutLog.push_back(2);
    dropped = '0;
    if (dropSrc >= 0) begin
      if (!hold[dropSrc]) rq[dropSrc] = 1'b0;
      owed[dropSrc] = 1'b0;
      dropped[dropSrc] = 1'b1;
      dropSrc = -1;
    end
    if (e != 0) dropSrc = respSrc;
  endtask

  task automatic decide();
    int w;
    if (rst && cyc >= freeCyc) begin
      if (!rq[2]) starve = 0;
      if (|rq) begin
        w = pickModel();
        respSrc = w;
        respCyc = cyc + L;
        freeCyc = respCyc + 1;
        respAddr = {ad[w][31:4], 4'h0};
        respData = w == 2 ? wData : pattern ^ (mixAddr ? {4{respAddr}} : 128'd0);
        owed[w] = 1'b1;
        lastWin = w;
        starve = w == 2 ? 0 : rq[2] ? starve + 1 : starve;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      decide();
    end
  endtask

  task automatic doReset(input bit keepReq);
    if (!keepReq) begin
      rq = '0;
      hold = '0;
    end
    rst = 1'b0;
    #1;
    chk("rstPulses", {dValid, iValid, wAck, memRE, memWE}, 5'd0);
    chk("rstAddr", memAddr, 32'd0);
    chk("rstWData", memWData, 128'd0);
    respSrc = -1; respCyc = -1; starve = 0; lastWin = 2; dropSrc = -1; owed = '0;
    dutLog.delete();
    step();
    step();
    rst = 1'b1;
    freeCyc = cyc;
    decide();
  endtask

  initial begin
    int idx;
    for (int s = 0; s < 3; s++) ad[s] = '0;
    // single i-cache read, latency and alignment
    doReset(0);
    pattern = {4{32'hA5A5A5A5}};
    step();
    rq[1] = 1'b1; ad[1] = 32'h00001234;
    decide();
    run(4);
    chk("t1Line", iLine, {4{32'hA5A5A5A5}});
    chk("t1Addr", memAddr, 32'h00001230);
    run(3);
    // simultaneous d and i
    doReset(0);
    step();
    rq[0] = 1'b1; rq[1] = 1'b1; ad[0] = 32'h0000_5678; ad[1] = 32'h0000_9ABC;
    decide();
    run(12);
    chk("t2Order", {dutLog.size() == 2 ? dutLog[0] : -1, dutLog.size() == 2 ? dutLog[1] : -1}, {32'd0, 32'd1});
    // write starved by a held d-cache read stream
    doReset(0);
    step();
    hold[0] = 1'b1; rq[0] = 1'b1; ad[0] = 32'h0000_0100;
    rq[2] = 1'b1; ad[2] = 32'h40; wData = {4{32'h11111111}};
    decide();
    run(100);
    idx = -1;
    foreach (dutLog[k]) if (idx < 0 && dutLog[k] == 2) idx = k;
`ifndef MEM_ARBITER_RR_EN
    chk("starveReads", idx, 8);
`else
    chk("rrWriteSecond", idx, 1);
`endif
    hold = '0;
    run(8);
    // reset while a write is in flight
    doReset(0);
    step();
    rq[2] = 1'b1; ad[2] = 32'h0000_0080; wData = {$urandom, $urandom, $urandom, $urandom};
    decide();
    run(2);
    doReset(1);
    run(8);
    chk("t4OneAck", dutLog.size(), 1);
    // latency-1 instance with a held request
    doReset(0);
    step();
    rq[0] = 1'b1; hold[0] = 1'b1; ad[0] = 32'h0000_2468;
    decide();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("lat1Valid", dValid1, k == 1 || k == 3);
      if (k == 1) chk("lat1Addr", memAddr1, 32'h0000_2460);
      decide();
    end
    hold = '0;
    run(8);
`ifdef MEM_ARBITER_RR_EN
    doReset(0);
    step();
    rq = 3'b111; hold = 3'b111;
    decide();
    run(30);
    for (int k = 0; k < 6; k++) chk("rrOrder", dutLog.size() > k ? dutLog[k] : -1, k % 3);
    hold = '0;
    run(8);
`endif
    // randomized traffic with post-grant address/data scrambling and early req drops
    doReset(0);
    mixAddr = 1'b1;
    pattern = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 400; n++) begin
      step();
      for (int s = 0; s < 3; s++) begin
        if (owed[s] && $urandom_range(3) == 0) begin
          ad[s] = $urandom;
          if (s == 2) wData = {$urandom, $urandom, $urandom, $urandom};
        end
        if (owed[s] && rq[s] && $urandom_range(7) == 0) rq[s] = 1'b0;
        if (!rq[s] && !owed[s] && !dropped[s] && $urandom_range(2) == 0) begin
          rq[s] = 1'b1;
          ad[s] = $urandom;
          if (s == 2) wData = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      decide();
    end
    rq = '0;
    run(12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
